// File: rtl/f_prefetch_buf_if.sv
// f_prefetch_buf_if: fetch-side push and decode-side pop handshakes of the prefetch queue
interface f_prefetch_buf_if #(parameter int AW = 2);
  logic          flush;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic [AW:0]   count;
  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );
  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/f_prefetch_buf.sv
// f_prefetch_buf: DEPTH-entry circular queue of {pc, instr} feeding decode; drives a NOP bubble when empty
module f_prefetch_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic clk,
  input logic reset,
  f_prefetch_buf_if.slave bus
);
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          push, pop;
  assign bus.in_ready  = cnt != (AW+1)'(DEPTH);
  assign bus.out_valid = cnt != '0;
  assign bus.count     = cnt;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;
  always_comb begin
    bus.out_pc    = bus.out_valid ? mem[rd_ptr][63:32] : 32'h0;
    bus.out_instr = bus.out_valid ? mem[rd_ptr][31:0]  : 32'h0;
  end
  always_ff @(posedge clk)
    if (!reset || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  // Storage is not reset; a word offered during reset or flush is dropped
  always_ff @(posedge clk)
    if (reset && !bus.flush && push) mem[wr_ptr] <= {bus.in_pc, bus.in_instr};
endmodule

// File: tb/tb_f_prefetch_buf.sv
// tb_f_prefetch_buf: scoreboard bench; expected words are queued on accepted pushes and compared at the head
module tb_f_prefetch_buf;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [63:0] sb[$];
  f_prefetch_buf_if #(.AW(AW)) bus();
  f_prefetch_buf #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cycle(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl, input logic rn);
    logic [31:0] ins;
    logic        do_push, do_pop;
    logic [63:0] head;
    ins = pc ^ 32'h2008_0005;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.flush     = fl;
    reset         = rn;
    #1;
    chk("count", 64'(bus.count), 64'(sb.size()));
    chk("in_ready", 64'(bus.in_ready), 64'(sb.size() != DEPTH));
    chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
    head = (sb.size() == 0) ? 64'h0 : sb[0];
    chk("head", {bus.out_pc, bus.out_instr}, head);
    do_push = iv && sb.size() != DEPTH;
    do_pop  = ordy && sb.size() != 0;
    if (!rn || fl) sb.delete();
    else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back({pc, ins});
    end
    @(posedge clk);
  endtask
  initial begin
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h0;
    bus.in_instr = 32'h0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    cycle(1, 32'h3000, 0, 0, 0);
    cycle(1, 32'h3000, 0, 0, 1);
    cycle(0, 32'h0, 1, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 32'h3000 + 32'(4 * i), 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 32'h0, 1, 0, 1);
    for (int i = 0; i < 20; i++) cycle(1, 32'h3000 + 32'(4 * i), 1, 0, 1);
    cycle(0, 32'h0, 1, 0, 1);
    cycle(0, 32'h0, 1, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 32'h5000 + 32'(4 * i), 0, 0, 1);
    cycle(1, 32'h5010, 1, 0, 1);
    cycle(1, 32'h5010, 0, 0, 1);
    cycle(0, 32'h0, 1, 0, 1);
    cycle(1, 32'h4000, 1, 1, 1);
    cycle(1, 32'h4000, 0, 0, 1);
    cycle(0, 32'h0, 1, 0, 1);
    cycle(0, 32'h0, 0, 0, 1);
    cycle(1, 32'h6000, 0, 0, 1);
    cycle(1, 32'h6004, 0, 0, 1);
    cycle(0, 32'h0, 0, 0, 0);
    cycle(0, 32'h0, 1, 0, 1);
    cycle(1, 32'h7000, 1, 0, 1);
    cycle(0, 32'h0, 1, 0, 1);
    cycle(0, 32'h0, 1, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
